// File: rtl/lfsr_10_checker.sv
// Receiver-side checker for the x^10+x^7+1 LFSR stream: blind sync, lock, flywheel error count.
// Optional build macro LFSR_CHK_PERIOD_EN adds a 1023-beat period check and the period_ok_o output.
module lfsr_10_checker #(
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned LOSS_CNT = 3,
   parameter int unsigned ERR_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             valid_i,
   input  logic [9:0]       data_i,
   output logic             locked_o,
   output logic             err_o,
   output logic [ERR_W-1:0] err_cnt_o,
`ifdef LFSR_CHK_PERIOD_EN
   output logic             period_ok_o,
`endif
   output logic             zero_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_LOCKED} state_e;

   localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
   localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

   function automatic logic [9:0] lfsr_next(input logic [9:0] x);
      return {x[7] ^ x[0], x[9:1]};
   endfunction

   state_e           state_q, state_d;
   logic [9:0]       exp_q, exp_d;
   logic             have_exp_q, have_exp_d;
   logic [3:0]       match_cnt_q, match_cnt_d;
   logic [3:0]       miss_cnt_q, miss_cnt_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic             zero_q, zero_d;

   logic             data_err;
   logic             per_err;
   logic             zero_set;
   logic [3:0]       match_inc;
   logic [3:0]       miss_inc;

   assign match_inc = match_cnt_q + 4'd1;
   assign miss_inc  = miss_cnt_q + 4'd1;

   // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      exp_d       = exp_q;
      have_exp_d  = have_exp_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      data_err    = 1'b0;
      zero_set    = 1'b0;

      if (!en_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d     = ST_SYNC;
               have_exp_d  = 1'b0;
               match_cnt_d = '0;
            end
            ST_SYNC: begin
               if (valid_i) begin
                  zero_set = (data_i == '0);
                  if (have_exp_q) begin
                     // The all-zero lock-up word never counts toward lock.
                     if (data_i == exp_q && data_i != '0) begin
                        match_cnt_d = match_inc;
                        if (match_inc == LOCK_C) begin
                           state_d    = ST_LOCKED;
                           miss_cnt_d = '0;
                        end
                     end else begin
                        match_cnt_d = '0;
                     end
                  end
                  exp_d      = lfsr_next(data_i);
                  have_exp_d = 1'b1;
               end
            end
            ST_LOCKED: begin
               if (valid_i) begin
                  zero_set = (data_i == '0);
                  // Flywheel: the expectation advances on its own, so one bad word is one error.
                  exp_d    = lfsr_next(exp_q);
                  if (data_i == exp_q) begin
                     miss_cnt_d = '0;
                  end else begin
                     data_err   = 1'b1;
                     miss_cnt_d = miss_inc;
                     if (miss_inc == LOSS_C) begin
                        state_d     = ST_SYNC;
                        exp_d       = lfsr_next(data_i);
                        have_exp_d  = 1'b1;
                        match_cnt_d = '0;
                     end
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

`ifdef LFSR_CHK_PERIOD_EN
   logic [9:0] per_cnt_q, per_cnt_d;
   logic [9:0] ref_q, ref_d;
   logic       have_ref_q, have_ref_d;
   logic       period_ok_q, period_ok_d;

   always_comb begin
      per_cnt_d   = per_cnt_q;
      ref_d       = ref_q;
      have_ref_d  = have_ref_q;
      period_ok_d = period_ok_q;
      per_err     = 1'b0;

      if (en_i && state_q == ST_LOCKED && valid_i) begin
         if (!have_ref_q) begin
            ref_d      = data_i;
            have_ref_d = 1'b1;
            per_cnt_d  = 10'd1;
         end else if (data_i == ref_q) begin
            if (per_cnt_q == 10'd1023) begin
               period_ok_d = 1'b1;
            end else begin
               per_err = 1'b1;
            end
            per_cnt_d = 10'd1;
         end else begin
            per_cnt_d = per_cnt_q + 10'd1;
         end
      end

      if (state_d != ST_LOCKED || state_q != ST_LOCKED) begin
         have_ref_d = 1'b0;
      end
      if (state_d != ST_LOCKED || clr_i) begin
         period_ok_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_cnt_q   <= '0;
         ref_q       <= '0;
         have_ref_q  <= 1'b0;
         period_ok_q <= 1'b0;
      end else begin
         per_cnt_q   <= per_cnt_d;
         ref_q       <= ref_d;
         have_ref_q  <= have_ref_d;
         period_ok_q <= period_ok_d;
      end
   end

   assign period_ok_o = period_ok_q;
`else
   assign per_err = 1'b0;
`endif

   // clr_i wins over a same-cycle increment or zero-set, but never suppresses the err pulse.
   always_comb begin
      err_d     = data_err | per_err;
      err_cnt_d = err_cnt_q;
      zero_d    = zero_q;
      if (clr_i) begin
         err_cnt_d = '0;
         zero_d    = 1'b0;
      end else begin
         if (err_d && err_cnt_q != {ERR_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
         end
         if (zero_set) begin
            zero_d = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         exp_q       <= '0;
         have_exp_q  <= 1'b0;
         match_cnt_q <= '0;
         miss_cnt_q  <= '0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
         zero_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         exp_q       <= exp_d;
         have_exp_q  <= have_exp_d;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
         zero_q      <= zero_d;
      end
   end

   assign locked_o  = (state_q == ST_LOCKED);
   assign err_o     = err_q;
   assign err_cnt_o = err_cnt_q;
   assign zero_o    = zero_q;

endmodule

// File: tb/tb_lfsr_10_checker.sv
// Bench for lfsr_10_checker: directed scenarios with random valid gaps, checked every cycle
// against a beat-level reference model of the sync/lock/flywheel rules.
module tb_lfsr_10_checker;

   localparam int ERR_W    = 4;
   localparam int LOCK_CNT = 4;
   localparam int LOSS_CNT = 3;
   localparam int CNT_MAX  = (1 << ERR_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en_i = 1'b0;
   logic             clr_i = 1'b0;
   logic             valid_i = 1'b0;
   logic [9:0]       data_i = '0;
   logic             locked_o;
   logic             err_o;
   logic [ERR_W-1:0] err_cnt_o;
   logic             zero_o;
`ifdef LFSR_CHK_PERIOD_EN
   logic             period_ok_o;
`endif

   lfsr_10_checker #(
      .LOCK_CNT (LOCK_CNT),
      .LOSS_CNT (LOSS_CNT),
      .ERR_W    (ERR_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (en_i),
      .clr_i     (clr_i),
      .valid_i   (valid_i),
      .data_i    (data_i),
      .locked_o  (locked_o),
      .err_o     (err_o),
      .err_cnt_o (err_cnt_o),
`ifdef LFSR_CHK_PERIOD_EN
      .period_ok_o (period_ok_o),
`endif
      .zero_o    (zero_o)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: tracks "checker active", "locked", how many consecutive
   // predicted words were seen, and what the next stream word should be.
   bit m_active, m_locked, m_primed, m_err, m_zero;
   int m_run, m_miss, m_exp, m_cnt;
   int src;

   function automatic int nxt(input int x);
      return (x >> 1) | ((((x >> 7) ^ x) & 1) << 9);
   endfunction

   task automatic model_reset();
      m_active = 0; m_locked = 0; m_primed = 0; m_err = 0; m_zero = 0;
      m_run = 0; m_miss = 0; m_exp = 0; m_cnt = 0;
   endtask

   task automatic model_clock(input bit en, input bit v, input int d, input bit clr);
      bit bump = 0;
      bit saw_zero = 0;
      m_err = 0;
      if (!en) begin
         m_active = 0;
         m_locked = 0;
      end else if (!m_active) begin
         m_active = 1;
         m_primed = 0;
         m_run    = 0;
      end else if (v) begin
         saw_zero = (d == 0);
         if (!m_locked) begin
            if (m_primed && d == m_exp && d != 0) begin
               m_run++;
               if (m_run == LOCK_CNT) begin
                  m_locked = 1;
                  m_miss   = 0;
               end
            end else if (m_primed) begin
               m_run = 0;
            end
            m_exp    = nxt(d);
            m_primed = 1;
         end else begin
            if (d == m_exp) begin
               m_miss = 0;
            end else begin
               m_err = 1;
               bump  = 1;
               m_miss++;
            end
            m_exp = nxt(m_exp);
            if (m_miss == LOSS_CNT) begin
               m_locked = 0;
               m_exp    = nxt(d);
               m_primed = 1;
               m_run    = 0;
            end
         end
      end
      if (clr) begin
         m_cnt  = 0;
         m_zero = 0;
      end else begin
         if (bump && m_cnt < CNT_MAX) m_cnt++;
         if (saw_zero) m_zero = 1;
      end
   endtask

   task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_all();
      compare("locked_o", 16'(locked_o), 16'(m_locked));
      compare("err_o", 16'(err_o), 16'(m_err));
      compare("err_cnt_o", 16'(err_cnt_o), 16'(m_cnt));
      compare("zero_o", 16'(zero_o), 16'(m_zero));
   endtask

   task automatic tick(input bit en, input bit v, input int d, input bit clr);
      en_i    = en;
      valid_i = v;
      data_i  = d[9:0];
      clr_i   = clr;
      @(posedge clk);
      model_clock(en, v, d, clr);
      #1;
      check_all();
   endtask

   task automatic good();
      tick(1, 1, src, 0);
      src = nxt(src);
   endtask

   task automatic bad(input int d);
      tick(1, 1, d, 0);
      src = nxt(src);
   endtask

   initial begin
      model_reset();
      #3;
      compare("reset_locked", 16'(locked_o), 16'd0);
      compare("reset_err", 16'(err_o), 16'd0);
      compare("reset_cnt", 16'(err_cnt_o), 16'd0);
      compare("reset_zero", 16'(zero_o), 16'd0);
      #9 rst_n = 1'b1;

      // Clean continuous stream from seed 0x001: lock right after the 5th beat.
      tick(1, 0, 0, 0);
      src = 1;
      for (int i = 1; i <= 5; i++) begin
         good();
         if (i == 4) compare("lock_early", 16'(locked_o), 16'd0);
      end
      compare("lock_5th", 16'(locked_o), 16'd1);
      for (int i = 6; i <= 2100; i++) good();
      compare("clean_cnt", 16'(err_cnt_o), 16'd0);

      // Single flipped bit 3.
      bad(src ^ 8);
      compare("flip_err", 16'(err_o), 16'd1);
      for (int i = 0; i < 5; i++) good();
      compare("flip_cnt", 16'(err_cnt_o), 16'd1);
      compare("flip_locked", 16'(locked_o), 16'd1);

      // Clear, then three consecutive 0x155 words drop lock; five good words relock.
      tick(1, 1, src, 1);
      src = nxt(src);
      bad('h155);
      bad('h155);
      compare("loss_hold", 16'(locked_o), 16'd1);
      bad('h155);
      compare("loss_drop", 16'(locked_o), 16'd0);
      compare("loss_cnt", 16'(err_cnt_o), 16'd3);
      for (int i = 0; i < 5; i++) good();
      compare("relock", 16'(locked_o), 16'd1);

      // Zero word in LOCKED, then clr_i together with another mismatch.
      bad(0);
      compare("zero_set", 16'(zero_o), 16'd1);
      compare("zero_cnt", 16'(err_cnt_o), 16'd4);
      tick(1, 1, src ^ 'h040, 1);
      src = nxt(src);
      compare("clr_err", 16'(err_o), 16'd1);
      compare("clr_cnt", 16'(err_cnt_o), 16'd0);
      compare("clr_zero", 16'(zero_o), 16'd0);
      for (int i = 0; i < 3; i++) good();

      // Disable, re-enable with ~40% valid duty on a clean stream.
      tick(0, 0, 0, 0);
      for (int i = 0; i < 600; i++) begin
         bit v;
         v = ($urandom_range(0, 99) < 40);
         tick(1, v, v ? src : int'($urandom_range(0, 1023)), 0);
         if (v) src = nxt(src);
      end
      compare("gap_locked", 16'(locked_o), 16'd1);
      compare("gap_cnt", 16'(err_cnt_o), 16'd0);
      bad(src ^ 1);
      tick(0, 1, src, 0);
      compare("dis_locked", 16'(locked_o), 16'd0);
      compare("dis_cnt_held", 16'(err_cnt_o), 16'd1);

      // Saturation: 20 isolated single-word errors while locked.
      tick(1, 0, 0, 1);
      for (int i = 0; i < 6; i++) good();
      for (int k = 0; k < 20; k++) begin
         bad(src ^ (1 << (k % 10)));
         good();
         good();
      end
      compare("sat_cnt", 16'(err_cnt_o), 16'(CNT_MAX));
      compare("sat_locked", 16'(locked_o), 16'd1);

      // Asynchronous reset mid-stream, then resynchronise from scratch.
      for (int i = 0; i < 3; i++) good();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      compare("arst_locked", 16'(locked_o), 16'd0);
      compare("arst_cnt", 16'(err_cnt_o), 16'd0);
      compare("arst_zero", 16'(zero_o), 16'd0);
      #2 rst_n = 1'b1;
      tick(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) good();
      compare("arst_relock", 16'(locked_o), 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
